// File: rtl/dbus_pkg.sv
// Shared types for the data-bus Wishbone bridge: FSM state encoding and
// the RV32I funct3 codes used for load/store sizing.
package dbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dbus_state_e;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

endpackage

// File: rtl/dbus_lane_align.sv
// Byte-lane steering for one access: store-side enables/replication,
// misalignment detect, and load-side lane extract with sign/zero extension.
module dbus_lane_align
  import dbus_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;

  // Move the addressed lane down to bit 0 before extending.
  assign w_shifted = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_sel        = 4'b1111;
    o_wdata      = i_wdata;
    o_misaligned = (i_off != 2'b00);
    o_rdata      = i_rdata;
    case (i_op)
      MEM_B, MEM_BU: begin
        o_sel        = 4'b0001 << i_off;
        o_wdata      = {4{i_wdata[7:0]}};
        o_misaligned = 1'b0;
        o_rdata      = (i_op == MEM_B) ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                       : {24'h000000, w_shifted[7:0]};
      end
      MEM_H, MEM_HU: begin
        o_sel        = 4'b0011 << i_off;
        o_wdata      = {2{i_wdata[15:0]}};
        o_misaligned = i_off[0];
        o_rdata      = (i_op == MEM_H) ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                       : {16'h0000, w_shifted[15:0]};
      end
      default: begin
        o_sel        = 4'b1111;
        o_wdata      = i_wdata;
        o_misaligned = (i_off != 2'b00);
        o_rdata      = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/dbus_wb_master.sv
// MEM-stage load/store to classic single-access Wishbone bridge. One bus
// cycle per request; the pipeline is held until ack, err or timeout.
module dbus_wb_master
  import dbus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mem_addr_mem,
  input  logic [31:0] mem_wdata_mem,
  input  logic        mem_write_mem,
  input  logic        mem_read_mem,
  input  logic [2:0]  mem_op_mem,
  output logic [31:0] mem_rdata_mem,
  output logic        stall_pipl,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  dbus_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_off;
  logic [2:0]    r_op;

  logic          w_req;
  logic [1:0]    w_off;
  logic [2:0]    w_op;
  logic [3:0]    w_sel;
  logic [31:0]   w_wdata_rep;
  logic          w_misaligned;
  logic [31:0]   w_rdata_ext;

  assign w_req = mem_read_mem | mem_write_mem;

  // One aligner serves both directions: live request in IDLE, the latched
  // offset/op while waiting for the slave's read data.
  assign w_off = (r_state == ST_IDLE) ? mem_addr_mem[1:0] : r_off;
  assign w_op  = (r_state == ST_IDLE) ? mem_op_mem        : r_op;

  assign stall_pipl = reset_n &
                      ((r_state == ST_BUSY) | ((r_state == ST_IDLE) & w_req));

  dbus_lane_align u_align (
    .i_off        (w_off),
    .i_op         (w_op),
    .i_wdata      (mem_wdata_mem),
    .i_rdata      (wb_dat_i),
    .o_sel        (w_sel),
    .o_wdata      (w_wdata_rep),
    .o_misaligned (w_misaligned),
    .o_rdata      (w_rdata_ext)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_off         <= '0;
      r_op          <= '0;
      wb_adr_o      <= '0;
      wb_dat_o      <= '0;
      wb_sel_o      <= '0;
      wb_we_o       <= 1'b0;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      mem_rdata_mem <= '0;
      bus_err       <= 1'b0;
    end else begin
      // Result and error only live for the single DONE cycle.
      bus_err       <= 1'b0;
      mem_rdata_mem <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_off <= mem_addr_mem[1:0];
            r_op  <= mem_op_mem;
            if (w_misaligned) begin
              bus_err <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              wb_adr_o <= {mem_addr_mem[31:2], 2'b00};
              wb_dat_o <= w_wdata_rep;
              wb_sel_o <= w_sel;
              wb_we_o  <= mem_write_mem;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              r_cnt    <= '0;
              r_state  <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (wb_err_i || (!wb_ack_i && (r_cnt == TO_LAST))) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            bus_err  <= 1'b1;
            r_state  <= ST_DONE;
          end else if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (!wb_we_o) begin
              mem_rdata_mem <= w_rdata_ext;
            end
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
